// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding, default operand width and counter sizing helper.
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_e;

    localparam int unsigned SA_DEFAULT_WIDTH = 32'd8;

    // Bit-counter width for a given operand width (at least one bit).
    function automatic int unsigned sa_cnt_width(input int unsigned w);
        return (w < 32'd2) ? 32'd1 : $clog2(w);
    endfunction

    localparam int unsigned SA_DEFAULT_CNT_W = sa_cnt_width(SA_DEFAULT_WIDTH);

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// One-bit full adder built only from two-input NAND gates.
// Purely combinational; the controller time-shares a single instance.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic n1_s;
    logic n2_s;
    logic n3_s;
    logic x_s;
    logic n4_s;
    logic n5_s;
    logic n6_s;

    // First half adder: x = a ^ b, n1 = ~(a & b)
    assign n1_s   = ~(a_i & b_i);
    assign n2_s   = ~(a_i & n1_s);
    assign n3_s   = ~(b_i & n1_s);
    assign x_s    = ~(n2_s & n3_s);

    // Second half adder: s = x ^ cin, n4 = ~(x & cin)
    assign n4_s   = ~(x_s & cin_i);
    assign n5_s   = ~(x_s & n4_s);
    assign n6_s   = ~(cin_i & n4_s);
    assign s_o    = ~(n5_s & n6_s);

    // Carry = (a & b) | (x & cin)
    assign cout_o = ~(n1_s & n4_s);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller. Latches operands on start, feeds one
// bit pair per clock (LSB first) through a shared full-adder cell, and
// publishes result/cout/overflow when the last bit is processed.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables the signed-overflow
// capture register; without it the overflow output is tied low.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned CNT_W = sa_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] acc_q, acc_d;        // sum bits collected so far
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shift_in_s;          // {new sum bit, collected bits}

    logic             fa_b_s;
    logic             fa_s_s;
    logic             fa_cout_s;

    assign fa_b_s     = b_sh_q[0] ^ sub_q;
    assign shift_in_s = {fa_s_s, acc_q};

    fa_cell u_fa_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (fa_b_s),
        .cin_i  (carry_q),
        .s_o    (fa_s_s),
        .cout_o (fa_cout_s)
    );

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // Next-state, datapath sequencing and output-register next values.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    carry_d = sub_i;       // +1 of the two's complement
                    sub_d   = sub_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = shift_in_s[WIDTH-1:1];
                carry_d = fa_cout_s;
                if (cnt_q == CNT_LAST) begin
                    // MSB: publish everything in the same edge.
                    result_d = shift_in_s;
                    cout_d   = fa_cout_s;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d    = carry_q ^ fa_cout_s;
`endif
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d  = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Signed-overflow capture register, updated together with result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign cout_o   = cout_q;

endmodule
